// File: rtl/mul_pkg.sv
// Shared multiply/divide package: FSM state encoding and default widths.
// The control unit uses the same encoding for its stall logic on both units.
package mul_pkg;

   localparam int unsigned MUL_WIDTH = 32;
   localparam int unsigned MUL_CNT_W = 6;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StFix  = 2'd2,
      StDone = 2'd3
   } mul_state_e;

endpackage

// File: rtl/mul_seq_if.sv
// Start/ready/done handshake and operand/result bus of the sequential multiplier.
interface mul_seq_if #(
   parameter int unsigned WIDTH = mul_pkg::MUL_WIDTH
);

   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] Multiplicand;
   logic [WIDTH-1:0] Multiplier;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;

   modport master (
      output start, is_signed, Multiplicand, Multiplier,
      input  ready, done, Hi, Lo
   );

   modport slave (
      input  start, is_signed, Multiplicand, Multiplier,
      output ready, done, Hi, Lo
   );

endinterface

// File: rtl/mul_step.sv
// One shift-and-add iteration: conditionally add the multiplicand to the
// upper accumulator half, keeping the carry so the shift loses nothing.
module mul_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] mcand,
   input  logic             lsb,
   output logic             carry,
   output logic [WIDTH-1:0] sum
);

   // 33-bit add; an lsb of 0 adds nothing.
   always_comb begin
      {carry, sum} = {1'b0, acc_hi} + (lsb ? {1'b0, mcand} : '0);
   end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-and-add multiplier for MULT/MULTU. Operands are reduced to
// magnitudes on accept, one multiplier bit is retired per RUN cycle, and the
// sign is restored by a single 64-bit negate in FIX.
module mul_seq
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_WIDTH,
   parameter int unsigned CNT_W = MUL_CNT_W
) (
   input logic     clk,
   input logic     rst,
   mul_seq_if.slave bus
);

   mul_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 neg_q, neg_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic                 step_carry;
   logic [WIDTH-1:0]     step_sum;
   logic                 a_neg;
   logic                 b_neg;

   mul_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc_hi (acc_q[2*WIDTH-1:WIDTH]),
      .mcand  (mcand_q),
      .lsb    (mplier_q[0]),
      .carry  (step_carry),
      .sum    (step_sum)
   );

   assign a_neg = bus.is_signed & bus.Multiplicand[WIDTH-1];
   assign b_neg = bus.is_signed & bus.Multiplier[WIDTH-1];

   // Next-state logic: accept, iterate, sign fix-up.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               neg_d    = a_neg ^ b_neg;
               // Unsigned magnitude, so |0x80000000| stays 0x80000000.
               mcand_d  = a_neg ? -bus.Multiplicand : bus.Multiplicand;
               mplier_d = b_neg ? -bus.Multiplier : bus.Multiplier;
               acc_d    = '0;
               cnt_d    = CNT_W'(WIDTH);
               state_d  = StRun;
            end else begin
               state_d  = StIdle;
            end
         end
         StRun: begin
            // {acc, mplier} >> 1 with the adder carry entering the top bit.
            acc_d    = {step_carry, step_sum, acc_q[WIDTH-1:1]};
            mplier_d = {acc_q[0], mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
            state_d      = StDone;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   // Handshake outputs decode directly from state so reset forces ready=1 at once.
   always_comb begin
      bus.ready = (state_q == StIdle) || (state_q == StDone);
      bus.done  = (state_q == StDone);
      bus.Hi    = hi_q;
      bus.Lo    = lo_q;
   end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: latency, signed/unsigned products, ignored
// start while busy, mid-operation reset and back-to-back operation.
module tb_mul_seq;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   n;
   int   pulses;
   int   first_done;
   int   second_done;
   logic early_ready;

   mul_seq_if #(.WIDTH(32)) bus ();

   mul_seq #(
      .WIDTH (32),
      .CNT_W (6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Accept one operation, scramble operands afterwards, wait for done.
   task automatic do_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
      @(negedge clk);
      bus.start        = 1'b1;
      bus.is_signed    = s;
      bus.Multiplicand = a;
      bus.Multiplier   = b;
      @(negedge clk);
      bus.start        = 1'b0;
      bus.is_signed    = ~s;
      bus.Multiplicand = $urandom;
      bus.Multiplier   = $urandom;
      n = 0;
      while (!bus.done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'd33);
      check({tag, " product"}, {bus.Hi, bus.Lo}, exp);
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      rst              = 1'b1;
      bus.start        = 1'b0;
      bus.is_signed    = 1'b0;
      bus.Multiplicand = '0;
      bus.Multiplier   = '0;

      @(negedge clk);
      check("reset ready", 64'(bus.ready), 64'd1);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset hi/lo", {bus.Hi, bus.Lo}, 64'd0);
      rst = 1'b0;

      do_op("u 6*7", 1'b0, 32'd6, 32'd7, 64'h00000000_0000002A);
      do_op("u ffff*ffff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
      do_op("s -3*5", 1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1);
      do_op("s min*min", 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
      do_op("s min*1", 1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000);
      do_op("u min*2", 1'b0, 32'h80000000, 32'h00000002, 64'h00000001_00000000);
      do_op("s 0*-5", 1'b1, 32'h00000000, 32'hFFFFFFFB, 64'h0);

      // start while busy must be ignored
      @(negedge clk);
      bus.start        = 1'b1;
      bus.is_signed    = 1'b0;
      bus.Multiplicand = 32'd5;
      bus.Multiplier   = 32'd5;
      @(negedge clk);
      bus.start   = 1'b0;
      n           = 0;
      early_ready = 1'b0;
      while (!bus.done && n < 100) begin
         if (n == 10) begin
            check("busy ready", 64'(bus.ready), 64'd0);
            bus.start        = 1'b1;
            bus.Multiplicand = 32'd2;
            bus.Multiplier   = 32'd3;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         n++;
         if (!bus.done && bus.ready) early_ready = 1'b1;
      end
      bus.start = 1'b0;
      check("busy latency", 64'(n), 64'd33);
      check("busy product", {bus.Hi, bus.Lo}, 64'd25);
      check("busy early ready", 64'(early_ready), 64'd0);
      @(negedge clk);
      check("busy done width", 64'(bus.done), 64'd0);

      // reset mid-operation
      @(negedge clk);
      bus.start        = 1'b1;
      bus.Multiplicand = 32'd7;
      bus.Multiplier   = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 1; i <= 17; i++) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort hi/lo", {bus.Hi, bus.Lo}, 64'd0);
      check("abort ready", 64'(bus.ready), 64'd1);
      check("abort done", 64'(bus.done), 64'd0);
      @(negedge clk);
      rst    = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) pulses++;
      end
      check("abort no done", 64'(pulses), 64'd0);
      do_op("u 9*9 after abort", 1'b0, 32'd9, 32'd9, 64'h51);

      // back-to-back: start held through the first DONE cycle
      @(negedge clk);
      bus.start        = 1'b1;
      bus.is_signed    = 1'b0;
      bus.Multiplicand = 32'd3;
      bus.Multiplier   = 32'd4;
      @(negedge clk);
      check("b2b busy", 64'(bus.ready), 64'd0);
      bus.Multiplicand = 32'd10;
      bus.Multiplier   = 32'd10;
      pulses      = 0;
      first_done  = -1;
      second_done = -1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (bus.done) begin
            pulses++;
            if (first_done < 0) begin
               first_done = i;
               check("b2b first product", {bus.Hi, bus.Lo}, 64'd12);
            end else if (second_done < 0) begin
               second_done = i;
               check("b2b second product", {bus.Hi, bus.Lo}, 64'd100);
            end
         end else if (pulses == 1) begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      check("b2b pulses", 64'(pulses), 64'd2);
      check("b2b first at", 64'(first_done), 64'd33);
      check("b2b spacing", 64'(second_done - first_done), 64'd34);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
